mask_stream_tx: RTL



---
 rtl/mask_stream_tx_pkg.sv | 23 ++
 rtl/mask_frame_ram.sv | 23 ++
 rtl/mask_stream_tx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mask_stream_tx_pkg.sv
// Shared definitions for the mask stream transmitter: FSM state encoding
// and the address-width helper used to size counters and RAM ports.
package mask_stream_tx_pkg;

  typedef enum logic [2:0] {
    FILL      = 3'd0,
    START     = 3'd1,
    SEND      = 3'd2,
    GAP       = 3'd3,
    KICK      = 3'd4,
    WAIT_DONE = 3'd5
  } tx_state_t;

  // Ceiling log2, never less than 1 so a degenerate size still gets a real bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/mask_frame_ram.sv
// One-bit-wide frame buffer holding a full binary mask. Writes happen while
// the frame is filling, reads while it is streaming; the two never overlap.
module mask_frame_ram #(
  parameter int WORDS = 65536,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  logic mem [WORDS];

  // Write on demand; read data is registered, giving one cycle of latency.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mask_stream_tx.sv
// Transmit side of the serial binary-mask interface. Thresholds incoming
// classifier pixels into a one-bit mask, buffers a full frame, streams it out
// gaplessly in raster order after an enable pulse, waits a few idle cycles,
// fires enable_process, then waits for the filter's rx_done.
// Optional: define MASK_STATS_EN to add the white_count output, the number of
// mask bits set in the most recently completed frame.
module mask_stream_tx
  import mask_stream_tx_pkg::*;
#(
  parameter int WIDTH       = 256,
  parameter int DEPTH       = 256,
  parameter int COLOR_DEPTH = 8,
  parameter int THRESHOLD   = 128,
  parameter int PROC_GAP    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLOR_DEPTH-1:0] pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic                   image_input,
  output logic                   enable,
  output logic                   enable_process,
  input  logic                   rx_done,
  output logic                   busy
`ifdef MASK_STATS_EN
  ,
  output logic [clog2(WIDTH*DEPTH+1)-1:0] white_count
`endif
);

  localparam int N  = WIDTH * DEPTH;
  localparam int AW = clog2(N);
  localparam int GW = clog2(PROC_GAP);
  localparam logic [AW-1:0]          LAST_ADDR = AW'(N - 1);
  localparam logic [GW-1:0]          GAP_LOAD  = GW'(PROC_GAP - 1);
  localparam logic [COLOR_DEPTH-1:0] THRESH    = COLOR_DEPTH'(THRESHOLD);

  tx_state_t     state, next_state;
  logic [AW-1:0] addr, addr_inc;
  logic [GW-1:0] gap_cnt;
  logic          xfer, mask_bit, ram_rdata;
  logic          enable_d, enable_process_d;

  assign xfer     = (state == FILL) && pix_valid;
  assign mask_bit = (pix_in >= THRESH);
  assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + AW'(1);

  mask_frame_ram #(
    .WORDS (N),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (xfer),
    .waddr (addr),
    .wdata (mask_bit),
    .raddr (addr),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= next_state;
  end

  // Next-state decode; the read address wrapping back to 0 marks the last SEND cycle.
  always_comb begin
    next_state = state;
    case (state)
      FILL:      if (xfer && (addr == LAST_ADDR)) next_state = START;
      START:     next_state = SEND;
      SEND:      if (addr == '0) next_state = GAP;
      GAP:       if (gap_cnt == '0) next_state = KICK;
      KICK:      next_state = WAIT_DONE;
      WAIT_DONE: if (rx_done) next_state = FILL;
      default:   next_state = FILL;
    endcase
  end

  // Output decode: handshake flags from the current state, pulses from the next state.
  always_comb begin
    pix_ready        = (state == FILL);
    busy             = (state != FILL);
    image_input      = (state == SEND) && ram_rdata;
    enable_d         = (next_state == START);
    enable_process_d = (next_state == KICK);
  end

  // Pulse registers, so enable and enable_process coincide exactly with START and KICK.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable         <= 1'b0;
      enable_process <= 1'b0;
    end else begin
      enable         <= enable_d;
      enable_process <= enable_process_d;
    end
  end

  // Address and gap counters; the address runs one ahead of the streamed data.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        FILL:      if (xfer) addr <= addr_inc;
        START:     addr <= addr_inc;
        SEND: begin
          if (addr != '0) addr <= addr_inc;
          else            gap_cnt <= GAP_LOAD;
        end
        GAP:       if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        WAIT_DONE: if (rx_done) addr <= '0;
        default:   ;
      endcase
    end
  end

`ifdef MASK_STATS_EN
  localparam int CW = clog2(N + 1);

  logic [CW-1:0] white_acc;

  // Count accepted ones during FILL and publish the total as the frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      white_acc   <= '0;
      white_count <= '0;
    end else if (xfer) begin
      if (addr == LAST_ADDR) begin
        white_count <= white_acc + CW'(mask_bit);
        white_acc   <= '0;
      end else begin
        white_acc <= white_acc + CW'(mask_bit);
      end
    end
  end
`endif

endmodule
